sc_stream_decoder: RTL and testbench

- Stochastic-to-binary converter at the consumer end of the SC datapath.
- Counts ones in a unipolar bitstream (e.g. the output of the SC edge-detection pipeline) over a fixed window of 2^LEN_LOG2 valid samples.
- Returns the binary estimate through a valid/ready handshake for readback or pixel write-out.

---
 rtl/sc_pkg.sv | 14 +
 rtl/sc_window_counter.sv | 50 +++++
 rtl/sc_stream_decoder.sv | 107 ++++++++++
 tb/tb_sc_stream_decoder.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/sc_pkg.sv
// Shared definitions for the stochastic-computing datapath.
package sc_pkg;

  // Window length shared with the stochastic number generators so that
  // encoder and decoder windows line up.
  localparam int SC_LEN_LOG2_DEFAULT = 8;

  typedef enum logic [1:0] {
    SC_IDLE  = 2'd0,
    SC_ACCUM = 2'd1,
    SC_HOLD  = 2'd2
  } sc_dec_state_e;

endpackage

// File: rtl/sc_window_counter.sv
// Ones counter and sample counter for one conversion window.
module sc_window_counter
  import sc_pkg::*;
#(
  parameter int LEN_LOG2 = SC_LEN_LOG2_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              en,
  input  logic              bit_in,
  output logic [LEN_LOG2:0] count,
  output logic              last
);

  localparam int CW = LEN_LOG2 + 1;

  logic [LEN_LOG2:0]   ones_d, ones_q;
  logic [LEN_LOG2-1:0] smp_d, smp_q;

  // Next-count logic: clear wins over counting.
  always_comb begin
    ones_d = ones_q;
    smp_d  = smp_q;
    if (clear) begin
      ones_d = '0;
      smp_d  = '0;
    end else if (en) begin
      ones_d = ones_q + CW'(bit_in);
      smp_d  = smp_q + LEN_LOG2'(1);
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ones_q <= '0;
      smp_q  <= '0;
    end else begin
      ones_q <= ones_d;
      smp_q  <= smp_d;
    end
  end

  // count excludes the sample being presented this cycle; the owner adds it
  // when last is high so the final sample lands in the result.
  assign count = ones_q;
  assign last  = en && (smp_q == {LEN_LOG2{1'b1}});

endmodule

// File: rtl/sc_stream_decoder.sv
// Stochastic-to-binary converter: counts ones over a 2^LEN_LOG2 valid-sample
// window and returns the result through a valid/ready handshake.
//
// state | meaning
// IDLE  | waiting for start; value/sat hold the previous result
// ACCUM | counting valid samples of the current window
// HOLD  | result presented with value_valid until value_ready
module sc_stream_decoder
  import sc_pkg::*;
#(
  parameter int LEN_LOG2 = SC_LEN_LOG2_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                bit_in,
  input  logic                bit_valid,
  output logic                busy,
  output logic [LEN_LOG2-1:0] value,
  output logic                sat,
  output logic                value_valid,
  input  logic                value_ready
);

  localparam int CW = LEN_LOG2 + 1;

  sc_dec_state_e       state_d, state_q;
  logic [LEN_LOG2-1:0] value_d, value_q;
  logic                sat_d, sat_q;

  logic              cnt_clear;
  logic              cnt_en;
  logic [LEN_LOG2:0] cnt_count;
  logic              cnt_last;
  logic [LEN_LOG2:0] final_count;

  sc_window_counter #(
    .LEN_LOG2 (LEN_LOG2)
  ) u_window_counter (
    .clk    (clk),
    .reset  (reset),
    .clear  (cnt_clear),
    .en     (cnt_en),
    .bit_in (bit_in),
    .count  (cnt_count),
    .last   (cnt_last)
  );

  // Samples are only taken while accumulating, never on the start cycle.
  assign cnt_en      = bit_valid && (state_q == SC_ACCUM);
  assign final_count = cnt_count + CW'(bit_in);

  // Sequencing and result capture.
  always_comb begin
    state_d   = state_q;
    value_d   = value_q;
    sat_d     = sat_q;
    cnt_clear = 1'b0;
    case (state_q)
      SC_IDLE: begin
        if (start) begin
          cnt_clear = 1'b1;
          state_d   = SC_ACCUM;
        end
      end
      SC_ACCUM: begin
        if (cnt_last) begin
          // Only an all-ones window reaches 2^LEN_LOG2, flagged via sat.
          value_d = final_count[LEN_LOG2] ? {LEN_LOG2{1'b1}}
                                          : final_count[LEN_LOG2-1:0];
          sat_d   = final_count[LEN_LOG2];
          state_d = SC_HOLD;
        end
      end
      SC_HOLD: begin
        if (value_ready) begin
          if (start) begin
            cnt_clear = 1'b1;
            state_d   = SC_ACCUM;
          end else begin
            state_d = SC_IDLE;
          end
        end
      end
      default: state_d = SC_IDLE;
    endcase
  end

  // State and result registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= SC_IDLE;
      value_q <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      value_q <= value_d;
      sat_q   <= sat_d;
    end
  end

  assign busy        = (state_q == SC_ACCUM);
  assign value_valid = (state_q == SC_HOLD);
  assign value       = value_q;
  assign sat         = sat_q;

endmodule

// File: tb/tb_sc_stream_decoder.sv
// Directed bench for sc_stream_decoder with a 16-sample window.
module tb_sc_stream_decoder;

  localparam int L = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         bit_in;
  logic         bit_valid;
  logic         busy;
  logic [L-1:0] value;
  logic         sat;
  logic         value_valid;
  logic         value_ready;

  int checks = 0;
  int errors = 0;

  sc_stream_decoder #(
    .LEN_LOG2 (L)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .bit_in      (bit_in),
    .bit_valid   (bit_valid),
    .busy        (busy),
    .value       (value),
    .sat         (sat),
    .value_valid (value_valid),
    .value_ready (value_ready)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Start pulse with a valid 1 presented on the start cycle; it must not count.
  task automatic go;
    start     = 1'b1;
    bit_valid = 1'b1;
    bit_in    = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic feed(input logic [15:0] bits);
    for (int i = 0; i < 16; i++) begin
      bit_in    = bits[i];
      bit_valid = 1'b1;
      tick();
    end
    bit_valid = 1'b0;
    bit_in    = 1'b0;
  endtask

  initial begin
    logic [15:0] mask;
    int          vi;

    reset = 1'b0; start = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; value_ready = 1'b0;
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_vv", value_valid, 0);
    chk("rst_value", value, 0);
    chk("rst_sat", sat, 0);
    reset = 1'b1;
    tick();
    chk("idle_busy", busy, 0);

    // All-zero stream: busy cycles 1..16, result in cycle 17.
    start = 1'b1; bit_valid = 1'b1; bit_in = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("t1_busy", busy, 1);
      chk("t1_vv_low", value_valid, 0);
      tick();
    end
    bit_valid = 1'b0;
    chk("t1_vv", value_valid, 1);
    chk("t1_busy_end", busy, 0);
    chk("t1_value", value, 0);
    chk("t1_sat", sat, 0);
    value_ready = 1'b1;
    tick();
    chk("t1_vv_drop", value_valid, 0);
    value_ready = 1'b0;

    // Alternating stream with value_ready held high: one-cycle value_valid.
    value_ready = 1'b1;
    go();
    feed(16'h5555);
    chk("t2_vv", value_valid, 1);
    chk("t2_value", value, 8);
    chk("t2_sat", sat, 0);
    tick();
    chk("t2_vv_one_cycle", value_valid, 0);
    tick();
    chk("t2_idle", value_valid | busy, 0);
    value_ready = 1'b0;

    // All-ones stream saturates.
    go();
    feed(16'hFFFF);
    chk("t3_vv", value_valid, 1);
    chk("t3_value", value, 15);
    chk("t3_sat", sat, 1);
    value_ready = 1'b1;
    tick();
    value_ready = 1'b0;
    chk("t3_vv_drop", value_valid, 0);

    // Gapped stream: 24 cycles, 16 valid, 5 valid ones, invalid cycles carry 1.
    go();
    mask = 16'h8425;
    vi   = 0;
    for (int i = 0; i < 24; i++) begin
      bit_valid = (i % 3) != 0;
      if (bit_valid) begin
        bit_in = mask[vi];
        vi++;
      end else begin
        bit_in = 1'b1;
      end
      if (i == 23) chk("t4_busy_before_last", busy, 1);
      tick();
    end
    bit_valid = 1'b0; bit_in = 1'b0;
    chk("t4_vv", value_valid, 1);
    chk("t4_value", value, 5);
    chk("t4_sat", sat, 0);

    // Backpressure in HOLD with start pulses and live samples ignored.
    for (int c = 0; c < 10; c++) begin
      start     = (c == 3) || (c == 4);
      bit_valid = 1'b1;
      bit_in    = 1'b1;
      tick();
      chk("t5_hold_vv", value_valid, 1);
      chk("t5_hold_busy", busy, 0);
      chk("t5_hold_value", value, 5);
      chk("t5_hold_sat", sat, 0);
    end
    start = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
    value_ready = 1'b1; start = 1'b1;
    tick();
    value_ready = 1'b0; start = 1'b0;
    chk("t5_b2b_busy", busy, 1);
    chk("t5_b2b_vv", value_valid, 0);
    feed(16'h0007);
    chk("t5_vv", value_valid, 1);
    chk("t5_value", value, 3);
    chk("t5_sat", sat, 0);
    value_ready = 1'b1;
    tick();
    value_ready = 1'b0;

    // Asynchronous reset at sample 9 of an all-ones window.
    go();
    bit_valid = 1'b1; bit_in = 1'b1;
    repeat (9) tick();
    chk("t6_busy_pre", busy, 1);
    #2 reset = 1'b0;
    #1;
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_vv", value_valid, 0);
    chk("t6_rst_value", value, 0);
    chk("t6_rst_sat", sat, 0);
    tick(); tick();
    reset = 1'b1; bit_valid = 1'b0; bit_in = 1'b0;
    tick();
    chk("t6_idle_busy", busy, 0);
    chk("t6_idle_vv", value_valid, 0);
    go();
    feed(16'h5555);
    chk("t6_vv", value_valid, 1);
    chk("t6_value", value, 8);
    chk("t6_sat", sat, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
